// File: rtl/usb_buf_pkg.sv
// usb_buf_pkg: shared sizing and ownership-state encoding for the USB data buffer
package usb_buf_pkg;
   localparam int DEPTH_DEF = 64;
   localparam int PTR_W = 6;
   localparam int OCC_W = PTR_W + 1;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TX_MODE = 2'd1,
      RX_MODE = 2'd2,
      FLUSH   = 2'd3
   } bufModeType;
endpackage

// File: rtl/data_buffer_mem.sv
// data_buffer_mem: byte storage with one synchronous write port and one asynchronous read port
module data_buffer_mem
   import usb_buf_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] wr_addr,
   input  logic [7:0]       wr_data,
   input  logic [PTR_W-1:0] rd_addr,
   output logic [7:0]       rd_data
);
   logic [7:0] mem [DEPTH];
   // write the pushed byte at the clock edge; contents are never reset
   always_ff @(posedge clk)
      if (we) mem[wr_addr] <= wr_data;
   assign rd_data = mem[rd_addr];
endmodule

// File: rtl/data_buffer_ctrl.sv
// data_buffer_ctrl: shared byte FIFO owned alternately by the AHB side (TX) and USB side (RX)
module data_buffer_ctrl
   import usb_buf_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             store_tx_data,
   input  logic [7:0]       tx_data,
   input  logic             get_rx_data,
   input  logic             store_rx_packet_data,
   input  logic [7:0]       rx_packet_data,
   input  logic             get_tx_packet_data,
   output logic [7:0]       rx_data,
   output logic [7:0]       tx_packet_data,
   output logic [OCC_W-1:0] buffer_occupancy,
   output logic             ahb_ready,
   output logic             usb_ready,
   output logic [1:0]       buf_mode,
   output logic             buf_error
);
   bufModeType       state, state_nxt;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [OCC_W-1:0] occ_nxt;
   logic             push_ahb, push_usb, pop_ahb, pop_usb, push, pop;
   logic             full, empty, live, refused;
   logic [7:0]       wr_byte, rd_byte;

   assign full    = buffer_occupancy == OCC_W'(DEPTH);
   assign empty   = buffer_occupancy == '0;
   assign live    = !clear && state != FLUSH;
   assign push    = push_ahb | push_usb;
   assign pop     = pop_ahb | pop_usb;
   assign wr_byte = push_usb ? rx_packet_data : tx_data;

   data_buffer_mem #(.DEPTH(DEPTH)) u_mem (
      .clk     (clk),
      .we      (push),
      .wr_addr (wr_ptr),
      .wr_data (wr_byte),
      .rd_addr (rd_ptr),
      .rd_data (rd_byte)
   );

   // ownership state register
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) state <= IDLE;
      else        state <= state_nxt;

   // accept/refuse decisions and next ownership state; USB push wins a tie in IDLE
   always_comb begin
      push_ahb  = 1'b0;
      push_usb  = 1'b0;
      pop_ahb   = 1'b0;
      pop_usb   = 1'b0;
      state_nxt = state;
      case (state)
         IDLE: begin
            push_usb = live && store_rx_packet_data;
            push_ahb = live && store_tx_data && !store_rx_packet_data;
         end
         TX_MODE: begin
            push_ahb = live && store_tx_data && !full;
            pop_usb  = live && get_tx_packet_data && !empty;
         end
         RX_MODE: begin
            push_usb = live && store_rx_packet_data && !full;
            pop_ahb  = live && get_rx_data && !empty;
         end
         default: ;
      endcase
      occ_nxt = buffer_occupancy + OCC_W'(push) - OCC_W'(pop);
      if (clear) state_nxt = FLUSH;
      else case (state)
         IDLE:    state_nxt = push_usb ? RX_MODE : push_ahb ? TX_MODE : IDLE;
         TX_MODE,
         RX_MODE: state_nxt = occ_nxt == '0 ? IDLE : state;
         default: state_nxt = IDLE;
      endcase
      refused = (store_tx_data && !push_ahb) || (get_rx_data && !pop_ahb) ||
                (store_rx_packet_data && !push_usb) || (get_tx_packet_data && !pop_usb);
   end

   assign ahb_ready = push_ahb | pop_ahb;
   assign usb_ready = push_usb | pop_usb;
   assign buf_mode  = state;

   // pointers, occupancy, popped-byte registers and the refusal pulse; a flush empties the buffer
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         buffer_occupancy <= '0;
         rx_data          <= '0;
         tx_packet_data   <= '0;
         buf_error        <= 1'b0;
      end else begin
         buf_error <= refused && live;
         if (!live) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            buffer_occupancy <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            buffer_occupancy <= occ_nxt;
            if (pop_ahb) rx_data <= rd_byte;
            if (pop_usb) tx_packet_data <= rd_byte;
         end
      end
endmodule

// File: tb/tb_data_buffer_ctrl.sv
// tb_data_buffer_ctrl: directed vector table plus hand-written corner sequences for data_buffer_ctrl
module tb_data_buffer_ctrl;
   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       clear = 1'b0, store_tx_data = 1'b0, get_rx_data = 1'b0;
   logic       store_rx_packet_data = 1'b0, get_tx_packet_data = 1'b0;
   logic [7:0] tx_data = '0, rx_packet_data = '0;
   logic [7:0] rx_data, tx_packet_data;
   logic [6:0] buffer_occupancy;
   logic       ahb_ready, usb_ready, buf_error;
   logic [1:0] buf_mode;
   logic       a_rdy, u_rdy;
   int         n_cmp = 0, n_bad = 0;

   data_buffer_ctrl dut (
      .clk(clk), .n_rst(n_rst), .clear(clear),
      .store_tx_data(store_tx_data), .tx_data(tx_data),
      .get_rx_data(get_rx_data),
      .store_rx_packet_data(store_rx_packet_data), .rx_packet_data(rx_packet_data),
      .get_tx_packet_data(get_tx_packet_data),
      .rx_data(rx_data), .tx_packet_data(tx_packet_data),
      .buffer_occupancy(buffer_occupancy),
      .ahb_ready(ahb_ready), .usb_ready(usb_ready),
      .buf_mode(buf_mode), .buf_error(buf_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       clr, st_tx;
      logic [7:0] txd;
      logic       g_rx, st_rx;
      logic [7:0] rxd;
      logic       g_tx;
      logic       e_ahb, e_usb;
      logic [1:0] e_mode;
      logic [6:0] e_occ;
      logic       e_err;
      logic [7:0] e_txp, e_rxd;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic clr, input logic st_tx, input logic [7:0] txd, input logic g_rx,
                       input logic st_rx, input logic [7:0] rxd, input logic g_tx);
      @(negedge clk);
      clear = clr; store_tx_data = st_tx; tx_data = txd; get_rx_data = g_rx;
      store_rx_packet_data = st_rx; rx_packet_data = rxd; get_tx_packet_data = g_tx;
      #1;
      a_rdy = ahb_ready;
      u_rdy = usb_ready;
      @(posedge clk);
      #1;
   endtask

   vec_t vt [16];
   logic [7:0] q [$];
   logic [7:0] b, e;

   initial begin
      vt[0]  = '{0,1,8'h11,0,0,8'h00,0, 1,0,2'd1,7'd1,0,8'h00,8'h00};
      vt[1]  = '{0,1,8'h22,0,0,8'h00,0, 1,0,2'd1,7'd2,0,8'h00,8'h00};
      vt[2]  = '{0,1,8'h33,0,0,8'h00,0, 1,0,2'd1,7'd3,0,8'h00,8'h00};
      vt[3]  = '{0,1,8'h44,0,0,8'h00,0, 1,0,2'd1,7'd4,0,8'h00,8'h00};
      vt[4]  = '{0,0,8'h00,0,0,8'h00,1, 0,1,2'd1,7'd3,0,8'h11,8'h00};
      vt[5]  = '{0,0,8'h00,0,0,8'h00,1, 0,1,2'd1,7'd2,0,8'h22,8'h00};
      vt[6]  = '{0,0,8'h00,0,0,8'h00,1, 0,1,2'd1,7'd1,0,8'h33,8'h00};
      vt[7]  = '{0,0,8'h00,0,0,8'h00,1, 0,1,2'd0,7'd0,0,8'h44,8'h00};
      vt[8]  = '{0,0,8'h00,1,0,8'h00,0, 0,0,2'd0,7'd0,1,8'h44,8'h00};
      vt[9]  = '{0,0,8'h00,0,0,8'h00,0, 0,0,2'd0,7'd0,0,8'h44,8'h00};
      vt[10] = '{0,1,8'h55,0,1,8'h66,0, 0,1,2'd2,7'd1,1,8'h44,8'h00};
      vt[11] = '{0,1,8'h99,0,1,8'h77,0, 0,1,2'd2,7'd2,1,8'h44,8'h00};
      vt[12] = '{0,0,8'h00,1,0,8'h00,0, 1,0,2'd2,7'd1,0,8'h44,8'h66};
      vt[13] = '{0,0,8'h00,1,1,8'h88,0, 1,1,2'd2,7'd1,0,8'h44,8'h77};
      vt[14] = '{0,0,8'h00,0,0,8'h00,1, 0,0,2'd2,7'd1,1,8'h44,8'h77};
      vt[15] = '{0,0,8'h00,1,0,8'h00,0, 1,0,2'd0,7'd0,0,8'h44,8'h88};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_mode", buf_mode, 2'd0);
      chk("rst_occ", buffer_occupancy, 7'd0);
      chk("rst_err", buf_error, 1'b0);
      chk("rst_rxd", rx_data, 8'h00);
      chk("rst_txp", tx_packet_data, 8'h00);
      @(negedge clk);
      n_rst = 1'b1;

      for (int i = 0; i < 16; i++) begin
         step(vt[i].clr, vt[i].st_tx, vt[i].txd, vt[i].g_rx, vt[i].st_rx, vt[i].rxd, vt[i].g_tx);
         chk($sformatf("v%0d_ahb_ready", i), a_rdy, vt[i].e_ahb);
         chk($sformatf("v%0d_usb_ready", i), u_rdy, vt[i].e_usb);
         chk($sformatf("v%0d_mode", i), buf_mode, vt[i].e_mode);
         chk($sformatf("v%0d_occ", i), buffer_occupancy, vt[i].e_occ);
         chk($sformatf("v%0d_err", i), buf_error, vt[i].e_err);
         chk($sformatf("v%0d_txp", i), tx_packet_data, vt[i].e_txp);
         chk($sformatf("v%0d_rxd", i), rx_data, vt[i].e_rxd);
      end

      for (int i = 0; i < 10; i++) step(0, 1, 8'(i), 0, 0, 8'h00, 0);
      chk("flush_pre_occ", buffer_occupancy, 7'd10);
      step(1, 1, 8'hEE, 0, 0, 8'h00, 1);
      chk("flush_ahb_ready", a_rdy, 1'b0);
      chk("flush_usb_ready", u_rdy, 1'b0);
      chk("flush_mode", buf_mode, 2'd3);
      chk("flush_occ", buffer_occupancy, 7'd0);
      chk("flush_err", buf_error, 1'b0);
      step(0, 1, 8'hEE, 0, 0, 8'h00, 0);
      chk("flush_req_ready", a_rdy, 1'b0);
      chk("flush_idle_mode", buf_mode, 2'd0);
      chk("flush_idle_occ", buffer_occupancy, 7'd0);
      chk("flush_idle_err", buf_error, 1'b0);

      for (int i = 0; i < 64; i++) step(0, 0, 8'h00, 0, 1, 8'(i) ^ 8'hA5, 0);
      chk("full_mode", buf_mode, 2'd2);
      chk("full_occ", buffer_occupancy, 7'd64);
      step(0, 0, 8'h00, 0, 1, 8'hFF, 0);
      chk("ovf_usb_ready", u_rdy, 1'b0);
      chk("ovf_occ", buffer_occupancy, 7'd64);
      chk("ovf_err", buf_error, 1'b1);
      step(0, 0, 8'h00, 1, 1, 8'hFE, 0);
      chk("full_pp_usb_ready", u_rdy, 1'b0);
      chk("full_pp_ahb_ready", a_rdy, 1'b1);
      chk("full_pp_occ", buffer_occupancy, 7'd63);
      chk("full_pp_rxd", rx_data, 8'hA5);
      chk("full_pp_err", buf_error, 1'b1);
      for (int i = 1; i < 64; i++) begin
         step(0, 0, 8'h00, 1, 0, 8'h00, 0);
         chk($sformatf("drain%0d_rxd", i), rx_data, 8'(i) ^ 8'hA5);
      end
      chk("drain_mode", buf_mode, 2'd0);
      chk("drain_occ", buffer_occupancy, 7'd0);

      for (int i = 0; i < 60; i++) begin
         b = 8'(i * 7 + 3);
         q.push_back(b);
         step(0, 1, b, 0, 0, 8'h00, 0);
      end
      chk("wrap_fill_occ", buffer_occupancy, 7'd60);
      for (int i = 60; i < 130; i++) begin
         b = 8'(i * 7 + 3);
         e = q.pop_front();
         q.push_back(b);
         step(0, 1, b, 0, 0, 8'h00, 1);
         chk($sformatf("wrap%0d_txp", i), tx_packet_data, e);
         chk($sformatf("wrap%0d_occ", i), buffer_occupancy, 7'd60);
      end
      while (q.size() > 0) begin
         e = q.pop_front();
         step(0, 0, 8'h00, 0, 0, 8'h00, 1);
         chk("wrap_drain_txp", tx_packet_data, e);
      end
      chk("wrap_end_mode", buf_mode, 2'd0);
      chk("wrap_end_occ", buffer_occupancy, 7'd0);

      for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 0, 1, 8'hC0 + 8'(i), 0);
      step(0, 0, 8'h00, 1, 0, 8'h00, 0);
      chk("prerst_rxd", rx_data, 8'hC0);
      chk("prerst_occ", buffer_occupancy, 7'd4);
      @(negedge clk);
      get_rx_data = 1'b0;
      get_tx_packet_data = 1'b1;
      #2;
      n_rst = 1'b0;
      #1;
      chk("arst_mode", buf_mode, 2'd0);
      chk("arst_occ", buffer_occupancy, 7'd0);
      chk("arst_rxd", rx_data, 8'h00);
      chk("arst_txp", tx_packet_data, 8'h00);
      chk("arst_err", buf_error, 1'b0);
      get_tx_packet_data = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      step(0, 1, 8'h5A, 0, 0, 8'h00, 0);
      chk("postrst_ahb_ready", a_rdy, 1'b1);
      chk("postrst_mode", buf_mode, 2'd1);
      chk("postrst_occ", buffer_occupancy, 7'd1);
      step(0, 0, 8'h00, 0, 0, 8'h00, 1);
      chk("postrst_txp", tx_packet_data, 8'h5A);
      chk("postrst_idle", buf_mode, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
